// File: rtl/duck_flight_ctl_if.sv
// duck_flight_ctl_if: bundles the game-FSM controls and the sprite-renderer outputs of the duck controller
//   master: game side; drives game_enable/spawn_req/move_tick/shot_hit/speed_level/lfsr_number and observes the sprite outputs
//   slave : duck controller; produces xpos/ypos/duck_direction/duck_visible/duck_state/duck_dead/duck_escaped
interface duck_flight_ctl_if;
    logic        game_enable;
    logic        spawn_req;
    logic        move_tick;
    logic        shot_hit;
    logic [1:0]  speed_level;
    logic [9:0]  lfsr_number;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        duck_direction;
    logic        duck_visible;
    logic [2:0]  duck_state;
    logic        duck_dead;
    logic        duck_escaped;
    modport master (
        output game_enable, spawn_req, move_tick, shot_hit, speed_level, lfsr_number,
        input  xpos, ypos, duck_direction, duck_visible, duck_state, duck_dead, duck_escaped
    );
    modport slave (
        input  game_enable, spawn_req, move_tick, shot_hit, speed_level, lfsr_number,
        output xpos, ypos, duck_direction, duck_visible, duck_state, duck_dead, duck_escaped
    );
endinterface

// File: rtl/duck_flight_ctl.sv
// duck_flight_ctl: spawns a duck, moves it diagonally in fixed point with edge bounces, escape and hit/fall
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of duck_flight_ctl_if (game controls in, sprite position/state/pulses out)
module duck_flight_ctl #(
    parameter int X_MAX        = 1024,
    parameter int Y_GROUND     = 620,
    parameter int DUCK_W       = 96,
    parameter int DUCK_H       = 32,
    parameter int FRAC_BITS    = 24,
    parameter int X_SPEED      = 310,
    parameter int Y_SPEED      = 200,
    parameter int FALL_SPEED   = 1024,
    parameter int FLIGHT_TICKS = 600,
    parameter int HIT_TICKS    = 30
) (
    input logic              clk,
    input logic              rst_n,
    duck_flight_ctl_if.slave bus
);
    localparam int PW = 12 + FRAC_BITS;
    localparam int CW = $clog2((FLIGHT_TICKS > HIT_TICKS ? FLIGHT_TICKS : HIT_TICKS) + 1);
    // two guard bits so a step past either edge is seen as negative or over-limit instead of wrapping
    typedef logic signed [PW+1:0] wide_t;
    localparam wide_t X_LIM = wide_t'(X_MAX - DUCK_W) << FRAC_BITS;
    localparam wide_t Y_TOP = wide_t'(Y_GROUND - DUCK_H) << FRAC_BITS;
    localparam wide_t Y_GND = wide_t'(Y_GROUND) << FRAC_BITS;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPAWN  = 3'd1,
        FLY    = 3'd2,
        HIT    = 3'd3,
        FALL   = 3'd4,
        ESCAPE = 3'd5
    } state_t;
    state_t          state;
    logic [PW-1:0]   x, y, x_nxt, y_nxt;
    logic            dx, dy, dx_nxt, dy_nxt, vis, dead, esc;
    logic [CW-1:0]   cnt;
    logic [11:0]     lfsr12, sp_x;
    wide_t           step_x, step_y, x_raw, y_raw, y_fall;
    logic            x_lo, x_hi, y_lo, y_hi;
    always_comb begin
        step_x = wide_t'(X_SPEED) * wide_t'({1'b0, bus.speed_level} + 3'd1);
        step_y = wide_t'(Y_SPEED) * wide_t'({1'b0, bus.speed_level} + 3'd1);
        x_raw  = dx ? wide_t'(x) - step_x : wide_t'(x) + step_x;
        y_raw  = dy ? wide_t'(y) - step_y : wide_t'(y) + step_y;
        y_fall = wide_t'(y) + wide_t'(FALL_SPEED);
        // touching an edge counts as a bounce, so the flag flips on the tick the edge is reached
        x_lo   = x_raw <= wide_t'(0);
        x_hi   = x_raw >= X_LIM;
        y_lo   = y_raw <= wide_t'(0);
        y_hi   = y_raw >= Y_TOP;
        x_nxt  = x_lo ? '0 : x_hi ? X_LIM[PW-1:0] : x_raw[PW-1:0];
        y_nxt  = y_lo ? '0 : y_hi ? Y_TOP[PW-1:0] : y_raw[PW-1:0];
        dx_nxt = x_lo ? 1'b0 : x_hi ? 1'b1 : dx;
        dy_nxt = y_lo ? 1'b0 : y_hi ? 1'b1 : dy;
        lfsr12 = 12'(bus.lfsr_number);
        sp_x   = lfsr12 < 12'(X_MAX - DUCK_W) ? lfsr12 : lfsr12 - 12'(DUCK_W);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x     <= '0;
            y     <= Y_GND[PW-1:0];
            dx    <= 1'b0;
            dy    <= 1'b0;
            vis   <= 1'b0;
            dead  <= 1'b0;
            esc   <= 1'b0;
            cnt   <= '0;
        end else begin
            dead <= 1'b0;
            esc  <= 1'b0;
            if (!bus.game_enable) begin
                state <= IDLE;
                vis   <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: if (bus.spawn_req) begin
                        state <= SPAWN;
                        vis   <= 1'b1;
                        x     <= PW'(sp_x) << FRAC_BITS;
                        y     <= Y_TOP[PW-1:0];
                        dx    <= sp_x >= 12'(X_MAX / 2);
                        dy    <= 1'b1;
                        cnt   <= '0;
                    end
                    SPAWN: state <= FLY;
                    FLY: if (bus.shot_hit) begin
                        state <= HIT;
                        cnt   <= '0;
                    end else if (bus.move_tick) begin
                        x  <= x_nxt;
                        y  <= y_nxt;
                        dx <= dx_nxt;
                        dy <= dy_nxt;
                        if (cnt == CW'(FLIGHT_TICKS - 1)) begin
                            state <= ESCAPE;
                            dy    <= 1'b1;
                            cnt   <= '0;
                        end else
                            cnt <= cnt + CW'(1);
                    end
                    HIT: if (bus.move_tick) begin
                        if (cnt == CW'(HIT_TICKS - 1)) begin
                            state <= FALL;
                            cnt   <= '0;
                        end else
                            cnt <= cnt + CW'(1);
                    end
                    FALL: if (bus.move_tick) begin
                        if (y_fall >= Y_GND) begin
                            y     <= Y_GND[PW-1:0];
                            dead  <= 1'b1;
                            state <= IDLE;
                            vis   <= 1'b0;
                        end else
                            y <= y_fall[PW-1:0];
                    end
                    ESCAPE: if (bus.move_tick) begin
                        x  <= x_nxt;
                        dx <= dx_nxt;
                        if (y_lo) begin
                            y     <= '0;
                            esc   <= 1'b1;
                            state <= IDLE;
                            vis   <= 1'b0;
                        end else
                            y <= y_raw[PW-1:0];
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
    assign bus.xpos           = x[PW-1:FRAC_BITS];
    assign bus.ypos           = y[PW-1:FRAC_BITS];
    assign bus.duck_direction = dx;
    assign bus.duck_visible   = vis;
    assign bus.duck_state     = state;
    assign bus.duck_dead      = dead;
    assign bus.duck_escaped   = esc;
endmodule

// File: tb/tb_duck_flight_ctl.sv
// tb_duck_flight_ctl: directed vector table plus hand sequences for spawn, bounce, escape, hit/fall and abort
module tb_duck_flight_ctl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, sp = 1'b0, tk = 1'b0, ht = 1'b0;
    logic [1:0] spd = 2'd0;
    logic [9:0] lf = 10'd0;
    int         n_cmp = 0;
    int         n_bad = 0;

    duck_flight_ctl_if ia ();
    duck_flight_ctl_if ib ();
    assign ia.game_enable = en;
    assign ia.spawn_req   = sp;
    assign ia.move_tick   = tk;
    assign ia.shot_hit    = ht;
    assign ia.speed_level = spd;
    assign ia.lfsr_number = lf;
    assign ib.game_enable = en;
    assign ib.spawn_req   = sp;
    assign ib.move_tick   = tk;
    assign ib.shot_hit    = ht;
    assign ib.speed_level = spd;
    assign ib.lfsr_number = lf;

    duck_flight_ctl #(.FRAC_BITS(0), .X_SPEED(1), .Y_SPEED(1), .FALL_SPEED(8),
                      .FLIGHT_TICKS(2000), .HIT_TICKS(3))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    duck_flight_ctl #(.FRAC_BITS(0), .X_SPEED(1), .Y_SPEED(1), .FALL_SPEED(8),
                      .FLIGHT_TICKS(10), .HIT_TICKS(3))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tk = 1'b1;
            cyc();
            tk = 1'b0;
            cyc();
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string nm, input int st, input int x, input int y, input int dir, input int vis);
        chk({nm, " a.state"}, int'(ia.duck_state), st);
        chk({nm, " a.xpos"}, int'(ia.xpos), x);
        chk({nm, " a.ypos"}, int'(ia.ypos), y);
        chk({nm, " a.dir"}, int'(ia.duck_direction), dir);
        chk({nm, " a.vis"}, int'(ia.duck_visible), vis);
    endtask

    task automatic chk_b(input string nm, input int st, input int x, input int y, input int dead, input int esc);
        chk({nm, " b.state"}, int'(ib.duck_state), st);
        chk({nm, " b.xpos"}, int'(ib.xpos), x);
        chk({nm, " b.ypos"}, int'(ib.ypos), y);
        chk({nm, " b.dead"}, int'(ib.duck_dead), dead);
        chk({nm, " b.escaped"}, int'(ib.duck_escaped), esc);
    endtask

    task automatic spawn(input int lfsr);
        en = 1'b0;
        cyc();
        en = 1'b1;
        sp = 1'b1;
        lf = 10'(lfsr);
        cyc();
        sp = 1'b0;
        cyc();
    endtask

    typedef struct {
        logic       en, sp, tk, ht;
        logic [1:0] spd;
        logic [9:0] lf;
        int         st, x, y, dir, vis;
    } vec_t;
    vec_t tbl[21];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 10'd100,  1, 100, 588, 0, 1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 10'd100,  2, 100, 588, 0, 1};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 10'd100,  2, 101, 587, 0, 1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 10'd100,  2, 101, 587, 0, 1};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 10'd100,  2, 102, 586, 0, 1};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 10'd100,  2, 106, 582, 0, 1};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 10'd100,  2, 107, 581, 0, 1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd100,  0, 107, 581, 0, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 10'd100,  0, 107, 581, 0, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 10'd1000, 1, 904, 588, 1, 1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 10'd1000, 2, 904, 588, 1, 1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 10'd1000, 2, 903, 587, 1, 1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd1000, 0, 903, 587, 1, 0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 10'd928,  1, 832, 588, 1, 1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd928,  0, 832, 588, 1, 0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 10'd511,  1, 511, 588, 0, 1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd511,  0, 511, 588, 0, 0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 10'd512,  1, 512, 588, 1, 1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd512,  0, 512, 588, 1, 0};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 10'd512,  0, 512, 588, 1, 0};
        tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 10'd512,  0, 512, 588, 1, 0};

        cyc();
        cyc();
        chk_a("reset", 0, 0, 620, 0, 0);
        chk_b("reset", 0, 0, 620, 0, 0);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 21; i++) begin
            en  = tbl[i].en;
            sp  = tbl[i].sp;
            tk  = tbl[i].tk;
            ht  = tbl[i].ht;
            spd = tbl[i].spd;
            lf  = tbl[i].lf;
            cyc();
            chk_a($sformatf("vec%0d", i), tbl[i].st, tbl[i].x, tbl[i].y, tbl[i].dir, tbl[i].vis);
        end
        sp = 1'b0;
        tk = 1'b0;
        ht = 1'b0;
        spd = 2'd0;

        spawn(1000);
        chk_a("left spawn", 2, 904, 588, 1, 1);
        ticks(588);
        chk_a("top reach", 2, 316, 0, 1, 1);
        ticks(315);
        chk_a("near left", 2, 1, 315, 1, 1);
        ticks(1);
        chk_a("left clamp", 2, 0, 316, 0, 1);
        ticks(1);
        chk_a("left bounce", 2, 1, 317, 0, 1);

        spawn(100);
        ticks(588);
        chk_a("top clamp", 2, 688, 0, 0, 1);
        ticks(1);
        chk_a("top bounce", 2, 689, 1, 0, 1);
        ticks(239);
        chk_a("right clamp", 2, 928, 240, 1, 1);
        ticks(1);
        chk_a("right bounce", 2, 927, 241, 1, 1);
        spd = 2'd3;
        ticks(1);
        chk_a("speed x4", 2, 923, 245, 1, 1);
        ticks(85);
        chk_a("near bottom", 2, 583, 585, 1, 1);
        ticks(1);
        chk_a("bottom clamp", 2, 579, 588, 1, 1);
        ticks(1);
        chk_a("bottom bounce", 2, 575, 584, 1, 1);
        spd = 2'd0;

        spawn(100);
        ticks(9);
        chk_b("pre timeout", 2, 109, 579, 0, 0);
        ticks(1);
        chk_b("timeout", 5, 110, 578, 0, 0);
        ticks(577);
        chk_b("escape climb", 5, 687, 1, 0, 0);
        tk = 1'b1;
        cyc();
        tk = 1'b0;
        chk_b("escape top", 0, 688, 0, 0, 1);
        chk("escape vis", int'(ib.duck_visible), 0);
        cyc();
        chk_b("escape after", 0, 688, 0, 0, 0);

        spawn(100);
        ticks(9);
        tk = 1'b1;
        ht = 1'b1;
        cyc();
        tk = 1'b0;
        ht = 1'b0;
        chk_b("hit vs timeout", 3, 109, 579, 0, 0);
        cyc();
        sp = 1'b1;
        ht = 1'b1;
        cyc();
        sp = 1'b0;
        ht = 1'b0;
        chk_b("hit ignores", 3, 109, 579, 0, 0);
        ticks(2);
        chk_b("hit hold", 3, 109, 579, 0, 0);
        ticks(1);
        chk_b("fall entry", 4, 109, 579, 0, 0);
        ticks(5);
        chk_b("falling", 4, 109, 619, 0, 0);
        tk = 1'b1;
        sp = 1'b1;
        lf = 10'd300;
        cyc();
        tk = 1'b0;
        sp = 1'b0;
        chk_b("ground", 0, 109, 620, 1, 0);
        chk("ground vis", int'(ib.duck_visible), 0);
        cyc();
        chk_b("ground after", 0, 109, 620, 0, 0);

        spawn(100);
        ticks(3);
        chk_a("pre reset", 2, 103, 585, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("async reset", 0, 0, 620, 0, 0);
        chk_b("async reset", 0, 0, 620, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        spawn(200);
        chk_a("respawn", 2, 200, 588, 0, 1);
        ticks(9);
        tk = 1'b1;
        ht = 1'b1;
        cyc();
        tk = 1'b0;
        ht = 1'b0;
        ticks(3);
        ticks(2);
        chk_b("abort fall pre", 4, 209, 595, 0, 0);
        en = 1'b0;
        cyc();
        chk_b("abort fall", 0, 209, 595, 0, 0);
        chk("abort vis", int'(ib.duck_visible), 0);
        en = 1'b1;
        sp = 1'b1;
        lf = 10'd300;
        cyc();
        sp = 1'b0;
        chk_b("respawn b", 1, 300, 588, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
